button_debouncer: RTL and testbench

Conditions one raw, active-low board pushbutton into clean, single-cycle events for the rest of the design. It has a two-flop synchronizer, a debounce state machine and a hold timer. It produces a debounced level, press/release/long-press strobes and a wrapping 6-bit press count that can drive the LED bank directly. It sits between the button pin and any counter or LED logic that currently samples the pin raw.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debouncer.sv | 140 ++++++++++++++
 tb/tb_button_debouncer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton conditioning logic.
package btn_pkg;

    localparam int unsigned CNT_W         = 24;
    localparam int unsigned CLK_HZ        = 27000000;
    localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        LONG,
        DB_RELEASE
    } state_e;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return ms * CYCLES_PER_MS;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous board inputs.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces an active-low pushbutton into a clean level, press/release/long
// strobes and a wrapping 6-bit press count.
module button_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(10),
    parameter int unsigned LONG_CYCLES     = ms_to_cycles(500)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [5:0] press_count
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic             btn_act;
    logic             btn_s;
    state_e           state_q,         state_d;
    logic [CNT_W-1:0] db_cnt_q,        db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q,      hold_cnt_d;
    logic             long_done_q,     long_done_d;
    logic             pressed_q,       pressed_d;
    logic             press_pulse_q,   press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             long_pulse_q,    long_pulse_d;
    logic [5:0]       press_count_q,   press_count_d;

    assign btn_act = ~btn_n;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_act),
        .q   (btn_s)
    );

    // Debounce FSM; hold_cnt is frozen while a release is being qualified.
    always_comb begin
        state_d         = state_q;
        db_cnt_d        = db_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        long_done_d     = long_done_q;
        press_count_d   = press_count_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d       = HELD;
                    press_pulse_d = 1'b1;
                    hold_cnt_d    = '0;
                    press_count_d = press_count_q + 6'd1;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = '0;
                end else if (hold_cnt_q == LONG_LAST) begin
                    state_d      = LONG;
                    long_pulse_d = 1'b1;
                    long_done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            LONG: begin
                if (!btn_s) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = '0;
                end
            end
            DB_RELEASE: begin
                if (btn_s) begin
                    state_d = long_done_q ? LONG : HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d         = IDLE;
                    release_pulse_d = 1'b1;
                    long_done_d     = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pressed_d = (state_d == HELD) || (state_d == LONG) || (state_d == DB_RELEASE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            db_cnt_q        <= '0;
            hold_cnt_q      <= '0;
            long_done_q     <= 1'b0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            press_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            long_done_q     <= long_done_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            press_count_q   <= press_count_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized scoreboard bench for button_debouncer against a run-length model.
module tb_button_debouncer;

    localparam int unsigned D = 4;
    localparam int unsigned L = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [5:0] press_count;

    button_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    // kind is one-hot {long, release, press}
    typedef struct {
        int unsigned cyc;
        logic [2:0]  kind;
        int unsigned count;
    } ev_t;

    ev_t         sbq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    // Reference model: a level flips once D+1 consecutive synchronized samples
    // disagree with it; a long press is the L-th undisturbed held sample.
    bit          m_s1, m_s2;
    bit          m_level;
    int unsigned m_run;
    int unsigned m_held;
    bit          m_long_done;
    int unsigned m_count;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
        m_held = 0; m_long_done = 0; m_count = 0;
        sbq.delete();
    endtask

    task automatic push_ev(input logic [2:0] kind);
        ev_t e;
        e.cyc   = cyc;
        e.kind  = kind;
        e.count = m_count;
        sbq.push_back(e);
    endtask

    task automatic model_step();
        bit s;
        if (rst) begin
            model_reset();
            return;
        end
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = ~btn_n;
        if (s != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_run   = 0;
                m_level = s;
                if (s) begin
                    m_count     = (m_count + 1) % 64;
                    m_held      = 0;
                    m_long_done = 0;
                    push_ev(3'b001);
                end else begin
                    push_ev(3'b010);
                end
            end
        end else begin
            if (m_level && m_run == 0 && !m_long_done) begin
                m_held++;
                if (m_held == L) begin
                    m_long_done = 1;
                    push_ev(3'b100);
                end
            end
            m_run = 0;
        end
    endtask

    task automatic tick(input bit b, input bit r);
        @(posedge clk);
        cyc++;
        model_step();
        #2;
        btn_n = b;
        if (r && !rst) model_reset();
        rst = r;
    endtask

    task automatic drive(input bit b, input int unsigned n);
        repeat (n) tick(b, 1'b0);
    endtask

    // Monitor: pops on every strobe and checks level/count each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (press_pulse || release_pulse || long_pulse) begin
                logic [2:0] act;
                act = {long_pulse, release_pulse, press_pulse};
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL strobe: unexpected strobes=%b at cycle %0d, none required", act, cyc);
                end else begin
                    ev_t e;
                    e = sbq.pop_front();
                    if (e.cyc != cyc || e.kind !== act || 6'(e.count) !== press_count) begin
                        errors++;
                        $display("FAIL strobe: got kind=%b cyc=%0d count=%0d, required kind=%b cyc=%0d count=%0d",
                                 act, cyc, press_count, e.kind, e.cyc, e.count);
                    end
                end
            end
            checks++;
            if (pressed !== m_level || press_count !== 6'(m_count)) begin
                errors++;
                $display("FAIL level: cycle %0d got pressed=%b count=%0d, required pressed=%b count=%0d",
                         cyc, pressed, press_count, m_level, m_count);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        btn_n = 1'b1;
        model_reset();
        repeat (3) tick(1'b1, 1'b1);
        drive(1'b1, 6);

        // clean press then release
        drive(1'b0, 20);
        drive(1'b1, 12);
        // bounce rejected
        drive(1'b0, 3); drive(1'b1, 1); drive(1'b0, 3); drive(1'b1, 12);
        // long press
        drive(1'b0, 30);
        drive(1'b1, 12);
        // release bounce while held
        drive(1'b0, 11); drive(1'b1, 2); drive(1'b0, 20); drive(1'b1, 12);
        // wrap the press counter
        repeat (64) begin
            drive(1'b0, 8);
            drive(1'b1, 8);
        end
        // reset while in LONG with the button still down
        drive(1'b0, 24);
        repeat (3) tick(1'b0, 1'b1);
        drive(1'b0, 14);
        drive(1'b1, 12);

        // random bursts, with occasional resets
        for (int i = 0; i < 400; i++) begin
            bit          b;
            int unsigned n;
            b = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(D + 2, 2 * L + D)
                                            : $urandom_range(1, D + 3);
            if ($urandom_range(0, 60) == 0) begin
                repeat ($urandom_range(1, 3)) tick(b, 1'b1);
            end
            drive(b, n);
        end

        drive(1'b1, 12);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d strobes never seen, required 0 outstanding", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
